// File: rtl/mc_ctrl_seq.sv
// Multi-cycle control sequencer for the 8-bit non-pipelined core.
// Fetches an instruction over a req/ack port, decodes it, and steps through
// EXEC / MEM / WB, driving ALU controls, the data-memory handshake and the
// register-file write strobe. Every output is a register loaded from the
// next-state decode, so it lines up exactly with the state it belongs to.
module mc_ctrl_seq #(
  parameter int PC_W        = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [7:0]      imem_rdata,
  output logic            alusrc,
  output logic [2:0]      alu_op,
  output logic [2:0]      imm,
  output logic            rs_sel,
  output logic            reg_waddr,
  output logic            reg_we,
  output logic            wb_sel,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            busy,
  output logic            fault,
  output logic [PC_W-1:0] pc
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_HALT = 3'b011;
  localparam logic [2:0] OP_ADDI = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_LW   = 3'b110;
  localparam logic [2:0] OP_SLL  = 3'b111;

  // A wait gives up after ACK_TIMEOUT request cycles with no ack; the timer
  // holds the number of ack-less cycles already spent, so the last allowed
  // cycle sees ACK_TIMEOUT-1 and an ack in that cycle still wins.
  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic [7:0]      timer_q, timer_d;
  logic            fault_q, fault_d;

  logic            imem_req_q, imem_req_d;
  logic            alusrc_q, alusrc_d;
  logic [2:0]      alu_op_q, alu_op_d;
  logic [2:0]      imm_q, imm_d;
  logic            rs_sel_q, rs_sel_d;
  logic            reg_waddr_q, reg_waddr_d;
  logic            reg_we_q, reg_we_d;
  logic            wb_sel_q, wb_sel_d;
  logic            dmem_req_q, dmem_req_d;
  logic            dmem_we_q, dmem_we_d;
  logic            busy_q, busy_d;

  logic [2:0]      op_q, op_d;
  logic            ctl_d;

  assign op_q = ir_q[7:5];
  assign op_d = ir_d[7:5];

  // Next-state, PC, instruction register and handshake timer.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    timer_d = '0;
    fault_d = fault_q;
    unique case (state_q)
      S_IDLE, S_HALT, S_FAULT: begin
        if (start) begin
          state_d = S_FETCH;
          fault_d = 1'b0;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end else if (timer_q >= TO_LAST) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_DECODE: begin
        unique case (op_q)
          OP_ADD, OP_SLL, OP_ADDI, OP_LW, OP_SW: state_d = S_EXEC;
          OP_HALT: begin
            state_d = S_HALT;
            pc_d    = pc_q + PC_W'(1);
          end
          default: begin
            state_d = S_FAULT;
            fault_d = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        if (op_q == OP_LW || op_q == OP_SW) state_d = S_MEM;
        else                                state_d = S_WB;
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (op_q == OP_SW) begin
            state_d = S_FETCH;
            pc_d    = pc_q + PC_W'(1);
          end else begin
            state_d = S_WB;
          end
        end else if (timer_q >= TO_LAST) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        pc_d    = pc_q + PC_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the state being entered, so the registered outputs
  // are valid for the whole of that state.
  always_comb begin
    ctl_d       = (state_d == S_DECODE) || (state_d == S_EXEC) ||
                  (state_d == S_MEM)    || (state_d == S_WB);
    imem_req_d  = (state_d == S_FETCH);
    alusrc_d    = ctl_d && (op_d == OP_ADD || op_d == OP_SLL);
    alu_op_d    = ctl_d ? op_d : 3'b000;
    imm_d       = ctl_d ? ir_d[2:0] : 3'b000;
    rs_sel_d    = ctl_d && ir_d[3];
    reg_waddr_d = ctl_d && ir_d[4];
    reg_we_d    = (state_d == S_WB);
    wb_sel_d    = (state_d == S_WB) && (op_d == OP_LW);
    dmem_req_d  = (state_d == S_MEM);
    dmem_we_d   = (state_d == S_MEM) && (op_d == OP_SW);
    busy_d      = !((state_d == S_IDLE) || (state_d == S_HALT) ||
                    (state_d == S_FAULT));
  end

  // Sequencer state and registered outputs; reset drops every strobe at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      timer_q     <= '0;
      fault_q     <= 1'b0;
      imem_req_q  <= 1'b0;
      alusrc_q    <= 1'b0;
      alu_op_q    <= 3'b000;
      imm_q       <= 3'b000;
      rs_sel_q    <= 1'b0;
      reg_waddr_q <= 1'b0;
      reg_we_q    <= 1'b0;
      wb_sel_q    <= 1'b0;
      dmem_req_q  <= 1'b0;
      dmem_we_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      timer_q     <= timer_d;
      fault_q     <= fault_d;
      imem_req_q  <= imem_req_d;
      alusrc_q    <= alusrc_d;
      alu_op_q    <= alu_op_d;
      imm_q       <= imm_d;
      rs_sel_q    <= rs_sel_d;
      reg_waddr_q <= reg_waddr_d;
      reg_we_q    <= reg_we_d;
      wb_sel_q    <= wb_sel_d;
      dmem_req_q  <= dmem_req_d;
      dmem_we_q   <= dmem_we_d;
      busy_q      <= busy_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign alusrc    = alusrc_q;
  assign alu_op    = alu_op_q;
  assign imm       = imm_q;
  assign rs_sel    = rs_sel_q;
  assign reg_waddr = reg_waddr_q;
  assign reg_we    = reg_we_q;
  assign wb_sel    = wb_sel_q;
  assign dmem_req  = dmem_req_q;
  assign dmem_we   = dmem_we_q;
  assign busy      = busy_q;
  assign fault     = fault_q;
  assign pc        = pc_q;

endmodule

// File: tb/tb_mc_ctrl_seq.sv
// Testbench for mc_ctrl_seq: directed instruction stream with an
// instruction-level model that lays out the expected output trace cycle by cycle.
module tb_mc_ctrl_seq;

  localparam int PC_W = 8;
  localparam int TO   = 15;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack = 1'b0;
  logic [7:0]      imem_rdata = 8'h00;
  logic            alusrc;
  logic [2:0]      alu_op;
  logic [2:0]      imm;
  logic            rs_sel;
  logic            reg_waddr;
  logic            reg_we;
  logic            wb_sel;
  logic            dmem_req;
  logic            dmem_we;
  logic            dmem_ack = 1'b0;
  logic            busy;
  logic            fault;
  logic [PC_W-1:0] pc;

  mc_ctrl_seq #(.PC_W(PC_W), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .alusrc(alusrc), .alu_op(alu_op), .imm(imm),
    .rs_sel(rs_sel), .reg_waddr(reg_waddr), .reg_we(reg_we), .wb_sel(wb_sel),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .busy(busy), .fault(fault), .pc(pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       alusrc;
    logic [2:0] alu_op;
    logic [2:0] imm;
    logic       rs_sel;
    logic       reg_waddr;
    logic       reg_we;
    logic       wb_sel;
    logic       dmem_req;
    logic       dmem_we;
    logic       busy;
    logic       fault;
    logic [7:0] pc;
  } obs_t;

  obs_t act, exp_cur;
  logic chk_en = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [7:0] m_pc    = 8'h00;
  logic       m_fault = 1'b0;

  always_comb begin
    act           = '0;
    act.imem_req  = imem_req;
    act.imem_addr = imem_addr;
    act.alusrc    = alusrc;
    act.alu_op    = alu_op;
    act.imm       = imm;
    act.rs_sel    = rs_sel;
    act.reg_waddr = reg_waddr;
    act.reg_we    = reg_we;
    act.wb_sel    = wb_sel;
    act.dmem_req  = dmem_req;
    act.dmem_we   = dmem_we;
    act.busy      = busy;
    act.fault     = fault;
    act.pc        = pc;
  end

  // Per-cycle comparison against the model trace, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      n_chk++;
      if (act !== exp_cur) begin
        n_fail++;
        $display("FAIL cycle_obs t=%0t actual=%h required=%h (fields req,addr,src,op,imm,rs,rd,we,wbs,dreq,dwe,busy,flt,pc)",
                 $time, act, exp_cur);
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] a, input logic [31:0] r);
    n_chk++;
    if (a !== r) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, a, r);
    end
  endtask

  function automatic obs_t idle_obs();
    obs_t o = '0;
    o.imem_addr = m_pc;
    o.pc        = m_pc;
    o.fault     = m_fault;
    return o;
  endfunction

  function automatic obs_t busy_obs();
    obs_t o = idle_obs();
    o.busy = 1'b1;
    return o;
  endfunction

  // ALU-facing fields for an instruction while it is in flight.
  function automatic obs_t ctl_obs(input logic [7:0] ins);
    obs_t o = busy_obs();
    logic [2:0] op = ins[7:5];
    o.alusrc    = (op == 3'b000) || (op == 3'b111);
    o.alu_op    = op;
    o.imm       = ins[2:0];
    o.rs_sel    = ins[3];
    o.reg_waddr = ins[4];
    return o;
  endfunction

  // One clock cycle: present inputs and the outputs expected during it.
  task automatic cyc(input obs_t e, input logic ia, input logic [7:0] rd,
                     input logic da, input logic st);
    imem_ack   = ia;
    imem_rdata = rd;
    dmem_ack   = da;
    start      = st;
    exp_cur    = e;
    chk_en     = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(idle_obs(), 1'b1, 8'hFF, 1'b1, 1'b0);
  endtask

  task automatic do_start();
    cyc(idle_obs(), 1'b0, 8'h00, 1'b0, 1'b1);
    m_fault = 1'b0;
  endtask

  // Execute one instruction from its first FETCH cycle. fw = fetch wait
  // cycles, mw = data wait cycles, noisy drives start and the unrelated ack
  // while busy, abort_mem >= 0 returns after that many MEM cycles.
  task automatic run_instr(input logic [7:0] ins, input int fw, input int mw,
                           input logic noisy, input int abort_mem);
    obs_t e;
    logic [2:0] op = ins[7:5];
    for (int i = 0; i <= fw; i++) begin
      e = busy_obs();
      e.imem_req = 1'b1;
      cyc(e, (i == fw), (i == fw) ? ins : ~ins, noisy, noisy);
    end
    cyc(ctl_obs(ins), noisy, ~ins, noisy, noisy);
    if (op == 3'b011) begin
      m_pc = m_pc + 8'd1;
      return;
    end
    if (op == 3'b001 || op == 3'b010) begin
      m_fault = 1'b1;
      return;
    end
    cyc(ctl_obs(ins), noisy, ~ins, noisy, noisy);
    if (op == 3'b110 || op == 3'b101) begin
      for (int i = 0; i <= mw; i++) begin
        if (i == abort_mem) return;
        e = ctl_obs(ins);
        e.dmem_req = 1'b1;
        e.dmem_we  = (op == 3'b101);
        cyc(e, noisy, ~ins, (i == mw), noisy);
      end
      if (op == 3'b101) begin
        m_pc = m_pc + 8'd1;
        return;
      end
    end
    e = ctl_obs(ins);
    e.reg_we = 1'b1;
    e.wb_sel = (op == 3'b110);
    cyc(e, noisy, ~ins, noisy, noisy);
    m_pc = m_pc + 8'd1;
  endtask

  task automatic fetch_timeout();
    obs_t e;
    for (int i = 0; i < TO; i++) begin
      e = busy_obs();
      e.imem_req = 1'b1;
      cyc(e, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    m_fault = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    lit("reset_strobes", {26'd0, imem_req, dmem_req, reg_we, busy, fault, alusrc}, 32'd0);
    lit("reset_alu_op", {29'd0, alu_op}, 32'd0);
    lit("reset_pc", {24'd0, pc}, 32'd0);
    rst_n = 1'b1;
    idle(2);
    do_start();

    run_instr(8'b000_1_0_000, 1, 0, 1'b0, -1);        // ADD
    lit("pc_after_add", {24'd0, pc}, 32'h01);
    run_instr(8'b100_0_0_101, 0, 0, 1'b1, -1);        // ADDI
    lit("pc_after_addi", {24'd0, pc}, 32'h02);
    run_instr(8'b110_1_0_010, 2, 3, 1'b0, -1);        // LW, 4 cycles of dmem_req
    run_instr(8'b101_0_1_001, 0, 1, 1'b1, -1);        // SW
    lit("pc_after_sw", {24'd0, pc}, 32'h04);
    run_instr(8'b111_0_1_011, 0, 0, 1'b0, -1);        // SLL
    run_instr(8'b000_0_1_110, TO - 1, 0, 1'b0, -1);   // ack on the last allowed cycle
    lit("late_ack_no_fault", {31'd0, fault}, 32'd0);

    run_instr(8'b001_0_0_000, 0, 0, 1'b0, -1);        // illegal
    idle(2);
    lit("illegal_fault", {31'd0, fault}, 32'd1);
    lit("illegal_pc_held", {24'd0, pc}, 32'h06);
    do_start();
    run_instr(8'b010_1_1_111, 0, 0, 1'b1, -1);        // illegal
    idle(1);
    do_start();
    fetch_timeout();
    idle(2);
    lit("timeout_fault", {31'd0, fault}, 32'd1);
    do_start();
    run_instr(8'b011_0_0_000, 0, 0, 1'b0, -1);        // HALT
    idle(3);
    lit("halt_pc", {24'd0, pc}, 32'h07);
    do_start();

    run_instr(8'b110_0_0_001, 0, 5, 1'b0, 2);         // LW, reset during MEM
    chk_en = 1'b0;
    lit("mem_req_before_rst", {31'd0, dmem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    lit("rst_drops_dmem_req", {31'd0, dmem_req}, 32'd0);
    lit("rst_pc", {24'd0, pc}, 32'h00);
    lit("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_pc    = 8'h00;
    m_fault = 1'b0;
    idle(2);
    do_start();

    run_instr(8'b000_0_0_000, 0, 0, 1'b0, -1);
    lit("pc_after_rst_add", {24'd0, pc}, 32'h01);
    while (m_pc != 8'hFF) run_instr(8'b000_0_0_001, 0, 0, 1'b0, -1);
    lit("pc_at_ff", {24'd0, pc}, 32'hFF);
    run_instr(8'b000_1_1_010, 0, 0, 1'b0, -1);
    lit("pc_wrap", {24'd0, pc}, 32'h00);
    run_instr(8'b000_0_0_000, 0, 0, 1'b0, -1);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
